// File: rtl/shift_seq_pkg.sv
// Shared constants for the shift command sequencer: FSM state codes and
// the {rotate,shift} operation encodings of the driven shift register.
package shift_seq_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] MODE_SHR = 2'b00;
    localparam logic [1:0] MODE_SHL = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

endpackage

// File: rtl/shift_seq_step.sv
// One step of the universal shift register, bit-exact with the real register:
// zero-fill shifts and wrap-around rotates selected by {rotate,shift}.
module shift_seq_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        next_q = q;
        case (mode)
            MODE_SHR: next_q = {1'b0, q[WIDTH-1:1]};
            MODE_SHL: next_q = {q[WIDTH-2:0], 1'b0};
            MODE_ROL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR: next_q = {q[0], q[WIDTH-1:1]};
            default:  next_q = q;
        endcase
    end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer driving a universal shift register. The register has no
// hold mode, so a shadow copy is reloaded on every non-operating cycle.
module shift_cmd_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_load,
    input  logic [1:0]       i_cmd_mode,
    input  logic [CNT_W-1:0] i_cmd_cnt,
    input  logic [WIDTH-1:0] i_cmd_data,
    output logic [WIDTH-1:0] o_load,
    output logic             o_en_load,
    output logic             o_rotate,
    output logic             o_shift,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_shadow
);

    logic [1:0]       state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_step;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] cap_data;
    logic [1:0]       cap_mode;

    shift_seq_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q      (shadow),
        .mode   (cap_mode),
        .next_q (shadow_step)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            shadow    <= '0;
            remaining <= '0;
            cap_data  <= '0;
            cap_mode  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        if (i_cmd_load) begin
                            cap_data <= i_cmd_data;
                            state    <= LOAD;
                        end else begin
                            cap_mode <= i_cmd_mode;
                            if (i_cmd_cnt == '0) begin
                                state <= DONE;
                            end else begin
                                remaining <= i_cmd_cnt;
                                state     <= RUN;
                            end
                        end
                    end
                end
                LOAD: begin
                    shadow <= cap_data;
                    state  <= DONE;
                end
                RUN: begin
                    // Shadow tracks the register, which steps on this same edge.
                    shadow    <= shadow_step;
                    remaining <= remaining - 1'b1;
                    if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_cmd_ready = (state == IDLE);
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        o_en_load   = (state != RUN);
        o_load      = (state == LOAD) ? cap_data : shadow;
        o_rotate    = 1'b0;
        o_shift     = 1'b0;
        if (state == RUN) begin
            o_rotate = cap_mode[1];
            o_shift  = cap_mode[0];
        end
        o_shadow    = shadow;
    end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
Command-driven control stage that sits directly upstream of universal_shift_register and drives its i_load, i_en_load, i_rotate and i_shift inputs.
- It accepts one command at a time over a valid/ready handshake: either a parallel load or a shift/rotate repeated N cycles.
- The shift register has no hold mode; it shifts every cycle unless loading. The sequencer therefore keeps a shadow copy of the register contents and re-loads it on every non-operating cycle to hold the value.
- The shadow is exported so downstream logic and benches can check the register without probing it.

Parameters:
WIDTH, 4, data width; equals the WIDTH of the driven shift register.
CNT_W, 4, width of the repeat count; at most 2^CNT_W-1 steps per command.

Ports:
i_clk  input  1  system clock; all state updates on rising edge.
i_rst  input  1  asynchronous active-low reset; shared with the shift register.
i_cmd_valid  input  1  command present.
o_cmd_ready  output  1  sequencer can accept a command.
i_cmd_load  input  1  1 = parallel load of i_cmd_data; 0 = shift/rotate command.
i_cmd_mode  input  2  {rotate,shift} operation: 00 shift right, 01 shift left, 10 rotate left, 11 rotate right.
i_cmd_cnt  input  CNT_W  number of steps; ignored for loads.
i_cmd_data  input  WIDTH  load value; ignored for shift/rotate commands.
o_load  output  WIDTH  to register i_load.
o_en_load  output  1  to register i_en_load.
o_rotate  output  1  to register i_rotate.
o_shift  output  1  to register i_shift.
o_busy  output  1  command in progress (state != IDLE).
o_done  output  1  one-cycle pulse when a command completes.
o_shadow  output  WIDTH  value the register holds after the current edge.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is asynchronous and active-low.
- While i_rst=0:
  - state=IDLE, shadow=0, remaining count=0, captured command cleared.
  - Outputs: o_cmd_ready=1, o_en_load=1, o_load=0, o_rotate=0, o_shift=0, o_busy=0, o_done=0, o_shadow=0.
- Output structure: Moore. All register-control outputs decode from state and flops only, never from i_cmd_* directly.
- Handshake: a command is accepted on a rising edge with i_cmd_valid=1 and o_cmd_ready=1.
  - o_cmd_ready=1 only in IDLE.
  - i_cmd_valid outside IDLE is ignored, not queued.
  - i_cmd_* are captured at acceptance and may change afterwards.
- State IDLE:
  - Drives o_en_load=1, o_load=shadow, o_rotate=o_shift=0, so the register holds.
  - On accept: load goes to LOAD; shift with cnt=0 goes to DONE; shift with cnt>0 goes to RUN with remaining=cnt.
- State LOAD (1 cycle):
  - Drives o_en_load=1, o_load=captured data.
  - At the edge: shadow<=data, go to DONE.
- State RUN:
  - Drives o_en_load=0, {o_rotate,o_shift}=captured mode, o_load=shadow.
  - Each edge: shadow<=step(shadow,mode), remaining<=remaining-1. When remaining==1 at the edge, go to DONE.
  - RUN lasts exactly cnt cycles.
- step() definition:
  - Shift right: {0,q[W-1:1]}, zero fill.
  - Shift left: {q[W-2:0],0}, zero fill.
  - Rotate left: {q[W-2:0],q[W-1]}.
  - Rotate right: {q[0],q[W-1:1]}.
  - This must match the shift register bit-exactly.
- State DONE (1 cycle):
  - o_done=1; drives hold (o_en_load=1, o_load=shadow); o_cmd_ready=0.
  - Next state IDLE.
- Latency (acceptance edge to o_done): load = 2 cycles; shift = cnt+1 cycles; cnt=0 = 1 cycle.
- Throughput: a new command can be accepted at earliest one cycle after o_done.
- Boundaries:
  - cnt = 2^CNT_W-1 is legal; no wrap of the remaining counter.
  - Rotate with cnt=WIDTH returns the original value.
  - Shifts with cnt>=WIDTH yield all zeros.
  - Reset asserted mid-LOAD/RUN/DONE aborts immediately: no o_done; shadow=0, consistent with the register reset.

Decomposition:
- Package shift_seq_pkg holds:
  - State enum: IDLE, LOAD, RUN, DONE.
  - Mode constants: MODE_SHR=2'b00, MODE_SHL=2'b01, MODE_ROL=2'b10, MODE_ROR=2'b11.
- One combinational sub-module, shift_seq_step (inputs q and mode, output next q), implements step(). The bench reuses it as the reference model.

Test Plan:
1. Reset: hold i_rst=0 for 2 clocks -> o_en_load=1, o_load=0000, o_shadow=0000, o_cmd_ready=1, o_done=0.
2. Load: accept load 1010 -> next cycle o_en_load=1, o_load=1010; then o_done=1, o_shadow=1010; register o_q=1010 and held for 5 idle cycles.
3. Shift right: from 1010, cnt=2, mode 00 -> 2 RUN cycles with o_en_load=0, rotate=0, shift=0; shadow 0101 then 0010; o_done; o_q holds 0010.
4. Rotate left then rotate right: load 1001, rotate left cnt=3 -> 0011, 0110, 1100; then rotate right cnt=4 -> back to 1100. o_q matches o_shadow every cycle.
5. cnt=0 and ignored valid: shift left cnt=0 -> o_done one cycle after acceptance, shadow unchanged. Pulse i_cmd_valid during RUN -> no acceptance, no state change.
6. Reset mid-RUN: rotate right cnt=15 from 1010, drop i_rst after 3 RUN cycles -> outputs take reset values asynchronously, no o_done, state IDLE after release.
